// File: rtl/usb_jtag_cmd_pkg.sv
// Shared opcodes, status bytes and parser state encoding for the USB-JTAG command sequencer.
package usb_jtag_cmd_pkg;
    localparam logic [7:0] OP_WR  = 8'h57;
    localparam logic [7:0] OP_RD  = 8'h52;
    localparam logic [7:0] ST_ACK = 8'h06;
    localparam logic [7:0] ST_NAK = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE, S_AH, S_AL, S_LEN, S_WDAT, S_WBUS, S_RBUS, S_TX
    } state_t;
endpackage

// File: rtl/usb_jtag_tx_slot.sv
// Single-byte TxD holding slot: keeps data/Start stable until Done, then forces one low cycle
// before the next byte so the bridge transmitter can re-arm.
module usb_jtag_tx_slot (
    input  logic       iCLK,
    input  logic       iRST_n,
    input  logic       iLoad,
    input  logic [7:0] iData,
    input  logic       iTxD_Done,
    output logic [7:0] oTxD_DATA,
    output logic       oTxD_Start,
    output logic       oDone,
    output logic       oIdle
);
    logic gap;

    assign oDone = oTxD_Start & iTxD_Done;
    assign oIdle = ~oTxD_Start & ~gap;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oTxD_DATA  <= 8'h00;
            oTxD_Start <= 1'b0;
            gap        <= 1'b0;
        end else begin
            gap <= 1'b0;
            if (oTxD_Start) begin
                if (iTxD_Done) begin
                    oTxD_Start <= 1'b0;
                    gap        <= 1'b1;
                end
            end else if (!gap && iLoad) begin
                oTxD_DATA  <= iData;
                oTxD_Start <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/usb_jtag_cmd_ctrl.sv
// Packet parser + register-bus sequencer behind the USB-JTAG byte link.
// Optional inter-byte RX timeout enabled by defining USB_JTAG_CMD_TIMEOUT_EN.
module usb_jtag_cmd_ctrl
    import usb_jtag_cmd_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 1 << 24
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic [7:0]        iRxD_DATA,
    input  logic              iRxD_Ready,
    output logic [7:0]        oTxD_DATA,
    output logic              oTxD_Start,
    input  logic              iTxD_Done,
    output logic [ADDR_W-1:0] oBUS_ADDR,
    output logic [7:0]        oBUS_WDATA,
    output logic              oBUS_WR,
    output logic              oBUS_RD,
    input  logic [7:0]        iBUS_RDATA,
    input  logic              iBUS_ACK,
    output logic              oBUSY,
    output logic              oERR
);
    state_t     state;
    logic [7:0] addrHi;
    logic [8:0] cnt;
    logic       isWr;
    logic [7:0] txByte;
    logic       txReq;
    logic       txDone, txIdle, txLoad, rdAck, toHit;
    logic [7:0] txData;

    // Read data bypasses txReq so the byte starts one cycle after the bus ACK.
    assign rdAck  = (state == S_RBUS) & oBUS_RD & iBUS_ACK;
    assign txLoad = rdAck | (txReq & txIdle);
    assign txData = rdAck ? iBUS_RDATA : txByte;
    assign oBUSY  = (state != S_IDLE);

    usb_jtag_tx_slot uTxSlot (
        .iCLK       (iCLK),
        .iRST_n     (iRST_n),
        .iLoad      (txLoad),
        .iData      (txData),
        .iTxD_Done  (iTxD_Done),
        .oTxD_DATA  (oTxD_DATA),
        .oTxD_Start (oTxD_Start),
        .oDone      (txDone),
        .oIdle      (txIdle)
    );

`ifdef USB_JTAG_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [TW-1:0] toCnt;
    logic          inParse;

    assign inParse = state inside {S_AH, S_AL, S_LEN, S_WDAT};
    assign toHit   = inParse & ~iRxD_Ready & (toCnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n)                    toCnt <= '0;
        else if (iRxD_Ready || !inParse) toCnt <= '0;
        else                            toCnt <= toCnt + TW'(1);
    end
`else
    assign toHit = 1'b0;
`endif

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state      <= S_IDLE;
            addrHi     <= 8'h00;
            oBUS_ADDR  <= '0;
            oBUS_WDATA <= 8'h00;
            oBUS_WR    <= 1'b0;
            oBUS_RD    <= 1'b0;
            cnt        <= 9'd0;
            isWr       <= 1'b0;
            txByte     <= 8'h00;
            txReq      <= 1'b0;
            oERR       <= 1'b0;
        end else begin
            oERR <= 1'b0;
            if (txReq && txIdle) txReq <= 1'b0;
            if (toHit) begin
                oERR  <= 1'b1;
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: if (iRxD_Ready) begin
                        if (iRxD_DATA == OP_WR || iRxD_DATA == OP_RD) begin
                            isWr  <= (iRxD_DATA == OP_WR);
                            state <= S_AH;
                        end else begin
                            // cnt cleared so S_TX returns to idle after the NAK
                            oERR   <= 1'b1;
                            cnt    <= 9'd0;
                            txByte <= ST_NAK;
                            txReq  <= 1'b1;
                            state  <= S_TX;
                        end
                    end
                    S_AH: if (iRxD_Ready) begin
                        addrHi <= iRxD_DATA;
                        state  <= S_AL;
                    end
                    S_AL: if (iRxD_Ready) begin
                        oBUS_ADDR <= ADDR_W'({addrHi, iRxD_DATA});
                        state     <= S_LEN;
                    end
                    S_LEN: if (iRxD_Ready) begin
                        cnt   <= {1'b0, iRxD_DATA} + 9'd1;
                        state <= isWr ? S_WDAT : S_RBUS;
                    end
                    S_WDAT: if (iRxD_Ready) begin
                        oBUS_WDATA <= iRxD_DATA;
                        state      <= S_WBUS;
                    end
                    S_WBUS: begin
                        if (!oBUS_WR) oBUS_WR <= 1'b1;
                        else if (iBUS_ACK) begin
                            oBUS_WR   <= 1'b0;
                            oBUS_ADDR <= oBUS_ADDR + ADDR_W'(1);
                            cnt       <= cnt - 9'd1;
                            if (cnt == 9'd1) begin
                                txByte <= ST_ACK;
                                txReq  <= 1'b1;
                                state  <= S_TX;
                            end else begin
                                state <= S_WDAT;
                            end
                        end
                    end
                    S_RBUS: begin
                        if (!oBUS_RD) oBUS_RD <= 1'b1;
                        else if (iBUS_ACK) begin
                            oBUS_RD   <= 1'b0;
                            oBUS_ADDR <= oBUS_ADDR + ADDR_W'(1);
                            cnt       <= cnt - 9'd1;
                            state     <= S_TX;
                        end
                    end
                    S_TX: if (txDone) state <= (cnt == 9'd0) ? S_IDLE : S_RBUS;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_usb_jtag_cmd_ctrl.sv
// Directed vector bench for usb_jtag_cmd_ctrl with bus/TxD responder models.
module tb_usb_jtag_cmd_ctrl;
    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [7:0]  rxData = 8'h00;
    logic        rxReady = 1'b0;
    logic [7:0]  oTxD_DATA;
    logic        oTxD_Start;
    logic        txDone = 1'b0;
    logic [15:0] oBUS_ADDR;
    logic [7:0]  oBUS_WDATA;
    logic        oBUS_WR, oBUS_RD;
    logic [7:0]  busRdata = 8'h00;
    logic        busAck = 1'b0, spurAck = 1'b0, ack;
    logic        oBUSY, oERR;

    assign ack = busAck | spurAck;
    always #5 clk = ~clk;

    usb_jtag_cmd_ctrl #(.ADDR_W(16), .TIMEOUT_CYC(100)) dut (
        .iCLK(clk), .iRST_n(rstN), .iRxD_DATA(rxData), .iRxD_Ready(rxReady),
        .oTxD_DATA(oTxD_DATA), .oTxD_Start(oTxD_Start), .iTxD_Done(txDone),
        .oBUS_ADDR(oBUS_ADDR), .oBUS_WDATA(oBUS_WDATA), .oBUS_WR(oBUS_WR), .oBUS_RD(oBUS_RD),
        .iBUS_RDATA(busRdata), .iBUS_ACK(ack), .oBUSY(oBUSY), .oERR(oERR)
    );

    int nChecks = 0, nErr = 0, cyc = 0;
    int ackDly = 0, txDly = 0, lastAckCyc = 0;
    int errCnt = 0, overlap = 0, unstable = 0;
    logic [15:0] wrA[$], rdA[$];
    logic [7:0]  wrD[$], rdQ[$], txLog[$];
    int          latLog[$];

    typedef struct {
        logic [0:7][7:0]  pkt;  int plen;
        logic [0:3][7:0]  rdat;
        int nwr; logic [0:3][15:0] wA; logic [0:3][7:0] wD;
        int nrd; logic [0:3][15:0] rA;
        int ntx; logic [0:3][7:0] tx;
        int lat; int nerr; int dly; int tdly; bit spur;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(negedge clk); rxData = b; rxReady = 1'b1;
        @(negedge clk); rxReady = 1'b0;
    endtask

    task automatic waitIdle(input string nm);
        int n = 0;
        while (oBUSY && n < 3000) begin @(negedge clk); n++; end
        chk({nm, " idle"}, oBUSY, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic waitWr(input int k);
        int n = 0;
        while (wrA.size() < k && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("write wait", wrA.size(), k);
    endtask

    task automatic clearLogs();
        wrA.delete(); wrD.delete(); rdA.delete(); rdQ.delete(); txLog.delete(); latLog.delete();
    endtask

    initial forever begin @(posedge clk); cyc++; end

    // Bus slave: ACKs after ackDly low-phase samples of an active strobe.
    int ackCnt = 0; bit ackGiven = 0;
    initial forever begin
        @(negedge clk);
        busAck = 1'b0;
        if ((oBUS_WR || oBUS_RD) && !ackGiven) begin
            if (ackCnt >= ackDly) begin
                busAck = 1'b1; ackGiven = 1; lastAckCyc = cyc;
                if (oBUS_WR) begin wrA.push_back(oBUS_ADDR); wrD.push_back(oBUS_WDATA); end
                else begin
                    rdA.push_back(oBUS_ADDR);
                    busRdata = (rdQ.size() > 0) ? rdQ.pop_front() : 8'hEE;
                end
            end else ackCnt++;
        end else if (!(oBUS_WR || oBUS_RD)) begin
            ackGiven = 0; ackCnt = 0;
        end
    end

    // TxD bridge model: logs each Start rise, answers Done after txDly cycles.
    bit txSeen = 0, txGiven = 0; int txN = 0;
    initial forever begin
        @(negedge clk);
        txDone = 1'b0;
        if (oBUS_RD && oTxD_Start) overlap++;
        if (oERR) errCnt++;
        if (oTxD_Start) begin
            if (!txSeen) begin
                txSeen = 1; txGiven = 0; txN = 0;
                txLog.push_back(oTxD_DATA); latLog.push_back(cyc - lastAckCyc);
            end else if (oTxD_DATA != txLog[$]) unstable++;
            if (!txGiven) begin
                if (txN >= txDly) begin txDone = 1'b1; txGiven = 1; end
                else txN++;
            end
        end else txSeen = 0;
    end

    initial begin
        int e0, n;
        vecs[0] = '{pkt:{8'h57,8'h12,8'h34,8'h00,8'hAB,24'h0}, plen:5, rdat:32'h0,
                    nwr:1, wA:{16'h1234,48'h0}, wD:{8'hAB,24'h0}, nrd:0, rA:64'h0,
                    ntx:1, tx:{8'h06,24'h0}, lat:2, nerr:0, dly:0, tdly:0, spur:0};
        vecs[1] = '{pkt:{8'h52,8'h00,8'h10,8'h02,32'h0}, plen:4, rdat:{8'h11,8'h22,8'h33,8'h00},
                    nwr:0, wA:64'h0, wD:32'h0, nrd:3, rA:{16'h0010,16'h0011,16'h0012,16'h0},
                    ntx:3, tx:{8'h11,8'h22,8'h33,8'h00}, lat:1, nerr:0, dly:2, tdly:1, spur:1};
        vecs[2] = '{pkt:{8'h99,56'h0}, plen:1, rdat:32'h0,
                    nwr:0, wA:64'h0, wD:32'h0, nrd:0, rA:64'h0,
                    ntx:1, tx:{8'h15,24'h0}, lat:-1, nerr:1, dly:0, tdly:2, spur:0};
        vecs[3] = '{pkt:{8'h57,8'hFF,8'hFF,8'h01,8'hA0,8'hA1,16'h0}, plen:6, rdat:32'h0,
                    nwr:2, wA:{16'hFFFF,16'h0000,32'h0}, wD:{8'hA0,8'hA1,16'h0}, nrd:0, rA:64'h0,
                    ntx:1, tx:{8'h06,24'h0}, lat:2, nerr:0, dly:1, tdly:0, spur:0};
        vecs[4] = '{pkt:{8'h52,8'hAB,8'hCD,8'h00,32'h0}, plen:4, rdat:{8'h5A,24'h0},
                    nwr:0, wA:64'h0, wD:32'h0, nrd:1, rA:{16'hABCD,48'h0},
                    ntx:1, tx:{8'h5A,24'h0}, lat:1, nerr:0, dly:3, tdly:0, spur:0};
        vecs[5] = '{pkt:{8'h57,8'h00,8'h00,8'h02,8'h01,8'h02,8'h03,8'h00}, plen:7, rdat:32'h0,
                    nwr:3, wA:{16'h0000,16'h0001,16'h0002,16'h0}, wD:{8'h01,8'h02,8'h03,8'h00},
                    nrd:0, rA:64'h0, ntx:1, tx:{8'h06,24'h0}, lat:2, nerr:0, dly:0, tdly:3, spur:0};

        repeat (3) @(negedge clk);
        chk("reset outs", {oTxD_DATA, oTxD_Start, oBUS_ADDR, oBUS_WDATA, oBUS_WR, oBUS_RD, oBUSY, oERR}, 0);
        rstN = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            ackDly = vecs[v].dly; txDly = vecs[v].tdly;
            clearLogs();
            for (int j = 0; j < vecs[v].nrd; j++) rdQ.push_back(vecs[v].rdat[j]);
            e0 = errCnt;
            for (int i = 0; i < vecs[v].plen; i++) begin
                if (vecs[v].pkt[0] == 8'h57 && i > 4) waitWr(i - 4);
                sendByte(vecs[v].pkt[i]);
                if (vecs[v].spur && i == vecs[v].plen - 1) begin
                    spurAck = 1'b1; @(negedge clk); spurAck = 1'b0;
                end
            end
            waitIdle($sformatf("v%0d", v));
            chk($sformatf("v%0d nwr", v), wrA.size(), vecs[v].nwr);
            for (int j = 0; j < vecs[v].nwr; j++) if (j < wrA.size()) begin
                chk($sformatf("v%0d wr%0d addr", v, j), wrA[j], vecs[v].wA[j]);
                chk($sformatf("v%0d wr%0d data", v, j), wrD[j], vecs[v].wD[j]);
            end
            chk($sformatf("v%0d nrd", v), rdA.size(), vecs[v].nrd);
            for (int j = 0; j < vecs[v].nrd; j++) if (j < rdA.size())
                chk($sformatf("v%0d rd%0d addr", v, j), rdA[j], vecs[v].rA[j]);
            chk($sformatf("v%0d ntx", v), txLog.size(), vecs[v].ntx);
            for (int j = 0; j < vecs[v].ntx; j++) if (j < txLog.size()) begin
                chk($sformatf("v%0d tx%0d", v, j), txLog[j], vecs[v].tx[j]);
                if (vecs[v].lat >= 0)
                    chk($sformatf("v%0d tx%0d latency", v, j), latLog[j], vecs[v].lat);
            end
            chk($sformatf("v%0d err pulses", v), errCnt - e0, vecs[v].nerr);
        end

        // oBUSY rises the cycle after the opcode byte; then the parser stalls mid-header.
        ackDly = 0; txDly = 0; clearLogs(); e0 = errCnt;
        @(negedge clk); rxData = 8'h57; rxReady = 1'b1;
        chk("busy with op byte", oBUSY, 0);
        @(negedge clk); rxReady = 1'b0;
        chk("busy after op byte", oBUSY, 1);
        sendByte(8'h12);
        repeat (150) @(negedge clk);
`ifdef USB_JTAG_CMD_TIMEOUT_EN
        chk("timeout err", errCnt - e0, 1);
        chk("timeout idle", oBUSY, 0);
        chk("timeout no tx", txLog.size(), 0);
`else
        chk("stall busy", oBUSY, 1);
        chk("stall no err", errCnt - e0, 0);
        sendByte(8'h34); sendByte(8'h00); sendByte(8'hAB);
        waitIdle("stall");
        chk("stall nwr", wrA.size(), 1);
        chk("stall wr addr", (wrA.size() > 0) ? wrA[0] : 16'h0, 16'h1234);
        chk("stall tx", (txLog.size() > 0) ? txLog[0] : 8'h0, 8'h06);
`endif

        // LEN=FF: 256 writes, count does not wrap at 256.
        clearLogs();
        sendByte(8'h57); sendByte(8'h00); sendByte(8'h00); sendByte(8'hFF);
        for (int i = 0; i < 256; i++) begin
            if (i > 0) waitWr(i);
            sendByte(i[7:0] ^ 8'h5A);
        end
        waitIdle("len256");
        chk("len256 nwr", wrA.size(), 256);
        chk("len256 addr128", (wrA.size() > 128) ? wrA[128] : 16'h0, 16'h0080);
        chk("len256 last addr", (wrA.size() > 255) ? wrA[255] : 16'h0, 16'h00FF);
        chk("len256 last data", (wrD.size() > 255) ? wrD[255] : 8'h0, 8'hA5);
        chk("len256 ntx", txLog.size(), 1);
        chk("len256 tx", (txLog.size() > 0) ? txLog[0] : 8'h0, 8'h06);

        // Reset while the write strobe is held drops the packet silently.
        ackDly = 20; clearLogs();
        sendByte(8'h57); sendByte(8'h12); sendByte(8'h34); sendByte(8'h00); sendByte(8'hAB);
        n = 0;
        while (!oBUS_WR && n < 20) begin @(negedge clk); n++; end
        chk("midwr strobe up", oBUS_WR, 1);
        rstN = 1'b0;
        #1;
        chk("midwr reset outs", {oTxD_DATA, oTxD_Start, oBUS_ADDR, oBUS_WDATA, oBUS_WR, oBUS_RD, oBUSY, oERR}, 0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        repeat (40) @(negedge clk);
        chk("midwr no tx", txLog.size(), 0);
        chk("midwr no write", wrA.size(), 0);
        chk("midwr idle", oBUSY, 0);

        chk("read/tx overlap", overlap, 0);
        chk("tx data stable", unstable, 0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErr);
        $finish;
    end
endmodule
